// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like master port between the fetch
// stage and the mem stage. One transaction is in flight at a time; the
// mem-stage access wins when both ports are pending. Per-port done flags
// keep a completed access from being re-issued until the pipeline advances,
// and a discard flag lets a flushed transaction finish on the bus without
// affecting the core.
module sram_like_arbiter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pipe_stall,
    input  logic        flush,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_stall,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_stall,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_I_ADDR = 3'd1,
        S_I_WAIT = 3'd2,
        S_D_ADDR = 3'd3,
        S_D_WAIT = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_m_req;

    logic        r_m_wr;
    logic [1:0]  r_m_size;
    logic [31:0] r_m_addr;
    logic [31:0] r_m_wdata;
    logic [31:0] r_inst_rdata;
    logic [31:0] r_data_rdata;
    logic        r_inst_done;
    logic        r_data_done;
    logic        r_discard;

    logic        w_inst_pend;
    logic        w_data_pend;
    logic        w_complete;
    logic        w_keep;
    logic        w_inst_fill;
    logic        w_data_fill;

    assign w_inst_pend = inst_req & ~r_inst_done;
    assign w_data_pend = data_req & ~r_data_done;

    // A completion is only meaningful in a WAIT state; it reaches the core
    // unless the transaction was flushed earlier or is being flushed now.
    assign w_complete  = m_data_ok & ((r_state == S_I_WAIT) | (r_state == S_D_WAIT));
    assign w_keep      = w_complete & ~r_discard & ~flush;
    assign w_inst_fill = w_keep & (r_state == S_I_WAIT);
    assign w_data_fill = w_keep & (r_state == S_D_WAIT);

    assign inst_stall  = w_inst_pend;
    assign data_stall  = w_data_pend;
    assign inst_rdata  = r_inst_rdata;
    assign data_rdata  = r_data_rdata;
    assign m_req       = w_m_req;
    assign m_wr        = r_m_wr;
    assign m_size      = r_m_size;
    assign m_addr      = r_m_addr;
    assign m_wdata     = r_m_wdata;

    // Next-state selection and master request decode.
    always_comb begin
        w_next  = r_state;
        w_m_req = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_data_pend) begin
                    w_next = S_D_ADDR;
                end else if (w_inst_pend) begin
                    w_next = S_I_ADDR;
                end
            end
            S_I_ADDR: begin
                w_m_req = 1'b1;
                if (m_addr_ok) begin
                    w_next = S_I_WAIT;
                end
            end
            S_I_WAIT: begin
                if (m_data_ok) begin
                    w_next = S_IDLE;
                end
            end
            S_D_ADDR: begin
                w_m_req = 1'b1;
                if (m_addr_ok) begin
                    w_next = S_D_WAIT;
                end
            end
            S_D_WAIT: begin
                if (m_data_ok) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture the request fields when leaving IDLE; they stay put until the next issue.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_m_wr    <= 1'b0;
            r_m_size  <= 2'd0;
            r_m_addr  <= 32'h0;
            r_m_wdata <= 32'h0;
        end else if (r_state == S_IDLE && w_next == S_D_ADDR) begin
            r_m_wr    <= data_wr;
            r_m_size  <= data_size;
            r_m_addr  <= data_addr;
            r_m_wdata <= data_wdata;
        end else if (r_state == S_IDLE && w_next == S_I_ADDR) begin
            r_m_wr    <= 1'b0;
            r_m_size  <= 2'd2;
            r_m_addr  <= inst_addr;
            r_m_wdata <= 32'h0;
        end
    end

    // Read-data holding registers, updated only by a non-discarded completion.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_inst_rdata <= 32'h0;
            r_data_rdata <= 32'h0;
        end else begin
            if (w_inst_fill) begin
                r_inst_rdata <= m_rdata;
            end
            if (w_data_fill) begin
                r_data_rdata <= m_rdata;
            end
        end
    end

    // Done flags: set by a kept completion, cleared by a pipeline advance or a flush.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_inst_done <= 1'b0;
            r_data_done <= 1'b0;
        end else if (flush) begin
            r_inst_done <= 1'b0;
            r_data_done <= 1'b0;
        end else begin
            if (!pipe_stall) begin
                r_inst_done <= 1'b0;
                r_data_done <= 1'b0;
            end
            if (w_inst_fill) begin
                r_inst_done <= 1'b1;
            end
            if (w_data_fill) begin
                r_data_done <= 1'b1;
            end
        end
    end

    // Discard marks an in-flight transaction whose result must be dropped.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_discard <= 1'b0;
        end else if (w_complete) begin
            r_discard <= 1'b0;
        end else if (flush && r_state != S_IDLE) begin
            r_discard <= 1'b1;
        end
    end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter
Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 resetn  in  1  reset, synchronous, active-low.
REQ-003 pipe_stall  in  1  global pipeline stall from the hazard unit (instruction, data and divider stalls ORed); 0 = pipeline advances this edge.
REQ-004 flush  in  1  exception flush (is_exceptM); 1 = in-flight core requests are squashed.
REQ-005 inst_req  in  1  fetch stage requests a word read at inst_addr; level, held until inst_stall=0.
REQ-006 inst_addr  in  32  fetch address.
REQ-007 inst_rdata  out  32  registered fetch data.
REQ-008 inst_stall  out  1  fetch not yet complete (drives instrStall).
REQ-009 data_req  in  1  mem stage requests an access; level.
REQ-010 data_wr  in  1  1 = write, 0 = read.
REQ-011 data_size  in  2  0 = byte, 1 = half, 2 = word.
REQ-012 data_addr  in  32  data address.
REQ-013 data_wdata  in  32  store data.
REQ-014 data_rdata  out  32  registered load data.
REQ-015 data_stall  out  1  data access not yet complete (drives dataStall).
REQ-016 m_req  out  1  shared sram-like master request.
REQ-017 m_wr  out  1  master write flag.
REQ-018 m_size  out  2  master size.
REQ-019 m_addr  out  32  master address.
REQ-020 m_wdata  out  32  master write data.
REQ-021 m_rdata  in  32  master read data, valid with m_data_ok.
REQ-022 m_addr_ok  in  1  address accepted; the request handshake completes when m_req=1 and m_addr_ok=1 on the same edge.
REQ-023 m_data_ok  in  1  transaction complete, one pulse per accepted address.
Function
REQ-024 The FSM SHALL have the states IDLE, I_ADDR, I_WAIT, D_ADDR and D_WAIT, with exactly one master transaction outstanding at any time.
REQ-025 In IDLE, (data_req & ~data_done) SHALL move to D_ADDR; otherwise (inst_req & ~inst_done) SHALL move to I_ADDR; when both are pending, data wins because the mem-stage instruction is older.
REQ-026 On entering I_ADDR or D_ADDR, m_wr, m_size, m_addr and m_wdata SHALL be latched from the core inputs (fetch: wr=0, size=2) and held constant until the next IDLE exit.
REQ-027 m_req SHALL equal 1 only in I_ADDR and D_ADDR.
REQ-028 In an ADDR state, m_addr_ok SHALL move the FSM to the matching WAIT state on the next edge.
REQ-029 In a WAIT state, m_data_ok SHALL return the FSM to IDLE, latch m_rdata into inst_rdata or data_rdata, and set inst_done or data_done, unless the discard flag is set.
REQ-030 m_data_ok in IDLE or in an ADDR state SHALL be ignored.
REQ-031 inst_stall SHALL equal inst_req & ~inst_done, and data_stall SHALL equal data_req & ~data_done, both purely combinational from registers and inputs.
REQ-032 Stall drops on the cycle after m_data_ok, giving a minimum access latency of 4 cycles from the request to stall=0 (IDLE -> ADDR -> WAIT -> done).
REQ-033 When pipe_stall=0 at an edge, inst_done and data_done SHALL clear, so each pipeline advance permits exactly one new access per port.
REQ-034 While done=1 and pipe_stall=1 (for example during a divider stall), no access SHALL be re-issued for that port.
REQ-035 flush=1 SHALL clear both done flags, and SHALL set discard if the FSM is in any non-IDLE state.
REQ-036 A discarded transaction SHALL still complete on the bus; its m_data_ok SHALL return the FSM to IDLE, clear discard, and change neither rdata register nor either done flag.
REQ-037 flush and m_data_ok on the same edge SHALL result in discard (no done set), and the FSM SHALL return to IDLE.
REQ-038 inst_rdata and data_rdata SHALL hold their values until the next non-discarded completion on their own port.
Reset
REQ-039 When resetn=0 at an edge, the following SHALL apply regardless of other inputs: state=IDLE; m_req=0; m_wr=0; m_size=0; m_addr=0; m_wdata=0; inst_rdata=0; data_rdata=0; inst_done=0; data_done=0; discard=0.
REQ-040 Reset asserted mid-transaction SHALL abandon it, and any later m_data_ok SHALL be ignored because the FSM is in IDLE.
Verification
REQ-041 Fetch: inst_req=1, addr 0xBFC00000; addr_ok on cycle 2, data_ok with rdata 0x3C1D0001 on cycle 4 -> m_addr=0xBFC00000, inst_stall=0 on cycle 5, inst_rdata=0x3C1D0001.
REQ-042 Simultaneous inst_req and data_req (load 0x80000010) -> the data access is issued first, the fetch follows after its m_data_ok, and both stalls stay 1 until the respective completion.
REQ-043 Store byte: data_wr=1, size=0, addr 0x80000003, wdata 0xAB; m_addr_ok delayed 3 cycles -> m_* remain stable and m_req=1 throughout.
REQ-044 Divider stall: inst_done=1 and pipe_stall=1 held for 10 cycles -> no new m_req; pipe_stall falls -> done clears and the next fetch issues.
REQ-045 flush during I_WAIT -> the returning data is dropped, inst_rdata is unchanged, the FSM returns to IDLE, and the new fetch to 0xBFC00380 is issued.
REQ-046 resetn=0 during D_WAIT followed by m_data_ok -> all outputs are 0 and no done flag is set.
